// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - divisor struct, minimum divisor and default-divisor helper for baud_gen_frac
package baud_pkg;

    // Widest divisor fields the helper can return; the top slices to its own widths.
    localparam int unsigned BAUD_DIV_W_MAX  = 32;
    localparam int unsigned BAUD_FRAC_W_MAX = 16;

    // Smallest integer divisor the counter can honour (one clock counting, one wrapping).
    localparam int unsigned BAUD_MIN_DIV    = 2;

    typedef struct packed {
        logic [BAUD_DIV_W_MAX-1:0]  div_int;
        logic [BAUD_FRAC_W_MAX-1:0] div_frac;
    } baud_div_t;

    // Clocks per oversample tick as a fixed-point value with frac_w fractional bits.
    function automatic baud_div_t baud_default_div(
        input longint clk_hz,
        input longint baud,
        input longint oversample,
        input int     frac_w
    );
        baud_div_t r;
        longint    q;
        longint    frac_mask;
        q         = (clk_hz << frac_w) / (baud * oversample);
        frac_mask = (longint'(1) << frac_w) - 1;
        r.div_int  = BAUD_DIV_W_MAX'(q >> frac_w);
        r.div_frac = BAUD_FRAC_W_MAX'(q & frac_mask);
        return r;
    endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// rtl/baud_gen_frac_if.sv - control and tick bundle between the UART path and baud_gen_frac
interface baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              resync;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_pending;
    logic              os_tick;
    logic              bit_tick;
    logic              mid_tick;

    // The UART side drives control and divisor, and consumes ticks.
    modport master (
        output en, resync, div_int, div_frac, div_load,
        input  div_pending, os_tick, bit_tick, mid_tick
    );

    // The generator side.
    modport slave (
        input  en, resync, div_int, div_frac, div_load,
        output div_pending, os_tick, bit_tick, mid_tick
    );
endinterface

// File: rtl/baud_frac_acc.sv
// rtl/baud_frac_acc.sv - fractional phase accumulator producing the one-clock period extension
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wrap,
    input  logic              i_resync,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_ext
);

    logic [FRAC_W-1:0] r_acc;
    logic              r_ext;
    logic [FRAC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

    // Add the active fraction once per period; the carry stretches the following period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (i_resync) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (i_wrap) begin
            r_acc <= w_sum[FRAC_W-1:0];
            r_ext <= w_sum[FRAC_W];
        end
    end

    assign o_ext = r_ext;

endmodule

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-divisor baud tick generator (fraction enabled by BAUD_GEN_FRAC_EN)
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 8,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic           clk,
    input  logic           rst,
    baud_gen_frac_if.slave bus
);

    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam baud_div_t         DEF_DIV  = baud_default_div(longint'(CLK_HZ), longint'(BAUD),
                                                              longint'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_DIV.div_int[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_DIV.div_frac[FRAC_W-1:0];
    localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(BAUD_MIN_DIV);
    localparam logic [OS_W-1:0]   IDX_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   IDX_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0]  r_count;
    logic [DIV_W-1:0]  r_active_int;
    logic [FRAC_W-1:0] r_active_frac;
    logic [DIV_W-1:0]  r_shadow_int;
    logic [FRAC_W-1:0] r_shadow_frac;
    logic              r_pending;
    logic [OS_W-1:0]   r_os_idx;
    logic              r_os_tick;
    logic              r_bit_tick;
    logic              r_mid_tick;

    logic [DIV_W-1:0]  w_eff_int;
    logic [DIV_W-1:0]  w_last;
    logic              w_ext;
    logic              w_at_last;
    logic              w_wrap;
    logic              w_switch;
    logic              w_have_new;
    logic [DIV_W-1:0]  w_next_int;
    logic [FRAC_W-1:0] w_next_frac;

`ifdef BAUD_GEN_FRAC_EN
    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk      (clk),
        .rst      (rst),
        .i_wrap   (w_wrap),
        .i_resync (bus.resync),
        .i_frac   (r_active_frac),
        .o_ext    (w_ext)
    );
`else
    logic w_unused_frac;
    assign w_ext         = 1'b0;
    assign w_unused_frac = ^r_active_frac;
`endif

    // Divisors below the minimum would leave no room for the wrap clock.
    assign w_eff_int  = (r_active_int < MIN_INT) ? MIN_INT : r_active_int;
    assign w_last     = w_eff_int - DIV_W'(1) + DIV_W'(w_ext);
    assign w_at_last  = (r_count == w_last);
    assign w_wrap     = bus.en && !bus.resync && w_at_last;

    // Points where a new divisor may take effect; a same-cycle load beats the older shadow.
    assign w_switch    = bus.resync || w_wrap;
    assign w_have_new  = bus.div_load || r_pending;
    assign w_next_int  = bus.div_load ? bus.div_int  : r_shadow_int;
    assign w_next_frac = bus.div_load ? bus.div_frac : r_shadow_frac;

    // Period counter and oversample index; resync restarts phase even while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_os_idx <= '0;
        end else if (bus.resync) begin
            r_count  <= '0;
            r_os_idx <= '0;
        end else if (bus.en) begin
            if (w_at_last) begin
                r_count  <= '0;
                r_os_idx <= (r_os_idx == IDX_LAST) ? '0 : r_os_idx + OS_W'(1);
            end else begin
                r_count  <= r_count + DIV_W'(1);
            end
        end
    end

    // Registered tick pulses, decoded from the index before it advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_tick  <= 1'b0;
            r_bit_tick <= 1'b0;
            r_mid_tick <= 1'b0;
        end else begin
            r_os_tick  <= w_wrap;
            r_bit_tick <= w_wrap && (r_os_idx == IDX_LAST);
            r_mid_tick <= w_wrap && (r_os_idx == IDX_MID);
        end
    end

    // Shadow capture and hand-over of the divisor at a period boundary or resync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_int  <= DEF_INT;
            r_active_frac <= DEF_FRAC;
            r_shadow_int  <= '0;
            r_shadow_frac <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (bus.div_load) begin
                r_shadow_int  <= bus.div_int;
                r_shadow_frac <= bus.div_frac;
            end
            if (w_switch) begin
                if (w_have_new) begin
                    r_active_int  <= w_next_int;
                    r_active_frac <= w_next_frac;
                end
                r_pending <= 1'b0;
            end else if (bus.div_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.div_pending = r_pending;
    assign bus.os_tick     = r_os_tick;
    assign bus.bit_tick    = r_bit_tick;
    assign bus.mid_tick    = r_mid_tick;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - scoreboard bench for baud_gen_frac against a tick-schedule model
module tb_baud_gen_frac;

    localparam int OS       = 8;
    localparam int FW       = 4;
    localparam int DEF_INT  = 1302;
    localparam int DEF_FRAC = 1;

    typedef struct {
        int cyc;
        bit b;
        bit m;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    baud_gen_frac_if #(.DIV_W(16), .FRAC_W(FW)) bif ();

    baud_gen_frac dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_os_seen = 0;
    int     cyc = 0;
    exp_t   expq[$];

    int     m_active_int, m_active_frac, m_shadow_int, m_shadow_frac;
    bit     m_pending;
    int     m_rem;
    longint m_fsum;
    int     m_tick_no;
    int     m_carry;
    exp_t   e_mod, e_mon;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    endtask

    function automatic int eff(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // A boundary (wrap or resync): the newest divisor, if any, becomes active.
    task automatic take_new();
        if (bif.div_load) begin
            m_shadow_int  = int'(bif.div_int);
            m_shadow_frac = int'(bif.div_frac);
            m_active_int  = m_shadow_int;
            m_active_frac = m_shadow_frac;
        end else if (m_pending) begin
            m_active_int  = m_shadow_int;
            m_active_frac = m_shadow_frac;
        end
        m_pending = 1'b0;
    endtask

    task automatic note_load();
        if (bif.div_load) begin
            m_shadow_int  = int'(bif.div_int);
            m_shadow_frac = int'(bif.div_frac);
            m_pending     = 1'b1;
        end
    endtask

    // Extra clock whenever the running total of fractions crosses a whole clock.
    task automatic frac_carry(output int c);
`ifdef BAUD_GEN_FRAC_EN
        longint old;
        old    = m_fsum;
        m_fsum = m_fsum + longint'(m_active_frac);
        c      = int'((m_fsum >> FW) - (old >> FW));
`else
        c = 0;
`endif
    endtask

    // Reference model: clocks remaining until the next tick, plus tick count since sync.
    always @(posedge clk) begin
        if (rst) begin
            m_active_int  = DEF_INT;
            m_active_frac = DEF_FRAC;
            m_shadow_int  = 0;
            m_shadow_frac = 0;
            m_pending     = 1'b0;
            m_rem         = DEF_INT;
            m_fsum        = 0;
            m_tick_no     = 0;
            cyc           = 0;
        end else begin
            cyc++;
            if (bif.resync) begin
                take_new();
                m_rem     = eff(m_active_int);
                m_fsum    = 0;
                m_tick_no = 0;
            end else if (bif.en) begin
                m_rem--;
                if (m_rem == 0) begin
                    e_mod.cyc = cyc;
                    e_mod.b   = (m_tick_no % OS) == OS - 1;
                    e_mod.m   = (m_tick_no % OS) == OS / 2 - 1;
                    expq.push_back(e_mod);
                    m_tick_no++;
                    frac_carry(m_carry);
                    take_new();
                    m_rem = eff(m_active_int) + m_carry;
                end else begin
                    note_load();
                end
            end else begin
                note_load();
            end
        end
    end

    // Monitor: compare every presented tick against the scoreboard, and flag missed ticks.
    always @(negedge clk) begin
        if (!rst) begin
            check("div_pending", longint'(bif.div_pending), longint'(m_pending));
            if (bif.os_tick || bif.bit_tick || bif.mid_tick) begin
                if (bif.os_tick) n_os_seen++;
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tick at cycle %0d: got os=%0b bit=%0b mid=%0b, required none",
                             cyc, bif.os_tick, bif.bit_tick, bif.mid_tick);
                end else begin
                    e_mon = expq.pop_front();
                    check("tick_cycle", longint'(cyc), longint'(e_mon.cyc));
                    check("os_tick",    longint'(bif.os_tick), 1);
                    check("bit_tick",   longint'(bif.bit_tick), longint'(e_mon.b));
                    check("mid_tick",   longint'(bif.mid_tick), longint'(e_mon.m));
                end
            end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
                e_mon = expq.pop_front();
                check("os_tick_missing", longint'(bif.os_tick), 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input int di, input int df);
        bif.div_int  = 16'(di);
        bif.div_frac = 4'(df);
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
    endtask

    task automatic pulse_resync();
        bif.resync = 1'b1;
        step(1);
        bif.resync = 1'b0;
    endtask

    int snap;

    initial begin
        bif.en       = 1'b0;
        bif.resync   = 1'b0;
        bif.div_load = 1'b0;
        bif.div_int  = '0;
        bif.div_frac = '0;

        step(3);
        check("reset_os_tick",     longint'(bif.os_tick), 0);
        check("reset_bit_tick",    longint'(bif.bit_tick), 0);
        check("reset_mid_tick",    longint'(bif.mid_tick), 0);
        check("reset_div_pending", longint'(bif.div_pending), 0);
        rst    = 1'b0;
        bif.en = 1'b1;

        // Default divisor: first tick at edge 1302, carry after the 16th wrap.
        step(18 * DEF_INT + 5);

        // 4 + 8/16 clocks per tick: 32 ticks span exactly 144 clocks.
        load(4, 8);
        step(3);
        pulse_resync();
        snap = n_os_seen;
        step(144);
`ifdef BAUD_GEN_FRAC_EN
        check("avg_4p5_tick_count", longint'(n_os_seen - snap), 32);
`else
        check("avg_4p5_tick_count", longint'(n_os_seen - snap), 36);
`endif

        // Mid-period load: the running period completes at the old length.
        step(2);
        load(10, 0);
        step(60);

        // Resync mid-bit with div_int=4.
        load(4, 0);
        step(23);
        pulse_resync();
        step(50);

        // Freeze for 50 cycles mid-period.
        step(2);
        bif.en = 1'b0;
        snap   = n_os_seen;
        step(50);
        check("en_low_no_ticks", longint'(n_os_seen - snap), 0);
        bif.en = 1'b1;
        step(30);

        // Divisors below the minimum clamp to a 2-clock period.
        load(0, 0);
        pulse_resync();
        step(20);
        load(1, 15);
        pulse_resync();
        step(40);

        // Randomised enable, resync and reload traffic.
        for (int i = 0; i < 20000; i++) begin
            bif.en       = ($urandom_range(0, 9) != 0);
            bif.resync   = ($urandom_range(0, 99) < 2);
            bif.div_load = ($urandom_range(0, 99) < 4);
            bif.div_int  = 16'($urandom_range(0, 12));
            bif.div_frac = 4'($urandom_range(0, 15));
            step(1);
        end
        bif.resync   = 1'b0;
        bif.div_load = 1'b0;
        bif.en       = 1'b1;
        step(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised, runtime-programmable baud tick generator replacing the fixed-divisor generator in the UART path. It produces a one-cycle oversample tick plus derived bit-boundary and mid-bit ticks. The divisor is integer plus fractional, so non-integer clock/baud ratios average out exactly. A resync input lets the UART receiver realign phase on a start-bit edge.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency
- BAUD, 9600, reset-time baud rate
- OVERSAMPLE, 8, os_tick pulses per bit; even, ≥4
- DIV_W, 16, width of integer divisor
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  count enable; low freezes all state, ticks forced 0
- resync  in  1  one-cycle pulse, restarts phase
- div_int  in  DIV_W  integer clocks per os_tick
- div_frac  in  FRAC_W  fractional clocks per os_tick
- div_load  in  1  capture div_int/div_frac into shadow
- div_pending  out  1  shadow captured, not yet active
- os_tick  out  1  oversample tick, one-cycle pulse
- bit_tick  out  1  last os_tick of a bit
- mid_tick  out  1  os_tick at bit centre

## Operation
- Reset defaults: active_int = CLK_HZ*2^FRAC_W/(BAUD*OVERSAMPLE) >> FRAC_W; active_frac = the low FRAC_W bits of the same quotient. For the defaults these are 1302 and 1. Reset also clears count, acc, ext, os_idx, shadow, div_pending and all ticks to 0.
- Counter: count runs 0..T, where T = active_int − 1 + ext. At count==T: count←0, os_tick_reg←1, os_idx advances modulo OVERSAMPLE. Otherwise count increments and os_tick_reg←0.
- Fractional carry: at each wrap, {c, acc} ← acc + active_frac and ext ← c. The next period is therefore active_int + c clocks long.
- Effective active_int < 2 is clamped to 2.
- bit_tick asserts with os_tick when the pre-advance os_idx == OVERSAMPLE−1. mid_tick asserts with os_tick when the pre-advance os_idx == OVERSAMPLE/2−1.
- div_load: shadow ← {div_int, div_frac} and div_pending ← 1. The shadow becomes active at the next wrap, and div_pending clears then.
  - div_load in the same cycle as a wrap: the new value governs the very next period.
  - Repeated div_load: the last one wins.
- resync: count, acc, ext and os_idx ← 0, with no tick that cycle. Any pending shadow is applied immediately. resync overrides en and a simultaneous wrap.
- en low: all state holds and div_load is still accepted. Ticks resume exactly where they stopped.

## Timing
- os_tick is registered and goes high on the edge after count==T. The first os_tick after reset release comes on the active_int-th rising edge.
- bit_tick and mid_tick are coincident with os_tick.
- After resync, the first os_tick arrives active_int edges later. The first mid_tick arrives OVERSAMPLE/2 os_ticks later.
- There is no combinational path from inputs to outputs.

## Configuration
- BAUD_GEN_FRAC_EN defined: fractional accumulator is present, as described above.
- BAUD_GEN_FRAC_EN undefined: acc and ext are constant 0, div_frac is ignored, and the period is always active_int clocks. div_pending behaviour is unchanged.

## Structure
- Package baud_pkg holds:
  - the default-divisor function (CLK_HZ, BAUD, OVERSAMPLE, FRAC_W → {int, frac})
  - the minimum-divisor constant (2)
  - a typedef for the {int, frac} divisor struct
- Sub-module baud_frac_acc holds the acc/ext register and carry logic, with inputs wrap, resync and frac. It is instantiated only under BAUD_GEN_FRAC_EN.

## Test plan
- Reset with defaults → first os_tick at edge 1302; the first carry (ext=1, 1303-clock period) follows the 16th wrap; bit_tick every 8th os_tick.
- div_int=4, div_frac=8, loaded then resync → os_tick spacings 4,4,5,4,5,…; average 4.5 over 32 ticks.
- div_load of div_int=10 mid-period → current period finishes at old length; div_pending high until that wrap; next spacing 10.
- resync asserted mid-bit (div_int=4) → no tick that cycle; next os_tick 4 edges later; mid_tick on the 4th os_tick after resync; bit_tick on the 8th.
- en low for 50 cycles mid-period → no ticks; count resumes and completes the remaining clocks exactly.
- div_int=0 or 1 → spacing 2 clocks; with BAUD_GEN_FRAC_EN undefined, div_frac=15 → spacing constant.
